// File: rtl/edge_arb_pkg.sv
// Shared constants and helpers for the edge event arbiter.
package edge_arb_pkg;

    localparam int N_DEFAULT = 4;

    // Index width that never collapses to zero bits for tiny channel counts.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first requester after 'last', modulo N.
module rr_arbiter
    import edge_arb_pkg::*;
#(
    parameter int N   = N_DEFAULT,
    parameter int IDW = clog2_min1(N)
) (
    input  logic [N-1:0]   req,
    input  logic [IDW-1:0] last,
    output logic           gnt_valid,
    output logic [IDW-1:0] gnt_id
);

    logic [2*N-1:0] w_dbl;
    logic [N-1:0]   w_rot;
    logic [IDW:0]   w_start;
    logic [IDW-1:0] w_off;
    logic [IDW:0]   w_sum;
    logic [IDW:0]   w_wrap;

    always_comb begin
        w_dbl   = {req, req};
        w_start = (IDW+1)'(last) + (IDW+1)'(1);
        // Bit k of w_rot is channel (last+1+k) mod N.
        w_rot   = N'(w_dbl >> w_start);
        w_off   = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (w_rot[k]) begin
                w_off = IDW'(k);
            end
        end
        w_sum     = w_start + (IDW+1)'(w_off);
        w_wrap    = (w_sum >= (IDW+1)'(N)) ? (w_sum - (IDW+1)'(N)) : w_sum;
        gnt_valid = |req;
        gnt_id    = IDW'(w_wrap);
    end

endmodule

// File: rtl/edge_event_arbiter.sv
// Collects masked rising edges per channel and serialises them round-robin
// onto one registered valid/ready event port; repeat edges while pending set overflow.
module edge_event_arbiter
    import edge_arb_pkg::*;
#(
    parameter int N   = N_DEFAULT,
    parameter int IDW = clog2_min1(N)
) (
    input  logic           clk,
    input  logic           resetn,
    input  logic [N-1:0]   din,
    input  logic [N-1:0]   mask,
    output logic           evt_valid,
    input  logic           evt_ready,
    output logic [IDW-1:0] evt_id,
    output logic [N-1:0]   overflow,
    input  logic [N-1:0]   clr_overflow
);

    logic [N-1:0]   r_din_q;
    logic [N-1:0]   r_pending;
    logic           r_evt_valid;
    logic [IDW-1:0] r_evt_id;
    logic [N-1:0]   r_overflow;
    logic [IDW-1:0] r_last;

    logic [N-1:0]   w_rise;
    logic           w_gnt_valid;
    logic [IDW-1:0] w_gnt_id;
    logic           w_load;
    logic [N-1:0]   w_load_vec;
    logic [N-1:0]   w_ovf_event;

    rr_arbiter #(.N(N), .IDW(IDW)) u_rr (
        .req       (r_pending),
        .last      (r_last),
        .gnt_valid (w_gnt_valid),
        .gnt_id    (w_gnt_id)
    );

    always_comb begin
        w_rise = din & ~r_din_q & mask;
        w_load = (~r_evt_valid | evt_ready) & w_gnt_valid;
        w_load_vec = '0;
        for (int i = 0; i < N; i++) begin
            if (w_load && (w_gnt_id == IDW'(i))) begin
                w_load_vec[i] = 1'b1;
            end
        end
        // A channel being loaded can accept a fresh edge without loss.
        w_ovf_event = w_rise & r_pending & ~w_load_vec;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_din_q     <= '0;
            r_pending   <= '0;
            r_evt_valid <= 1'b0;
            r_evt_id    <= '0;
            r_overflow  <= '0;
            r_last      <= IDW'(N - 1);
        end else begin
            r_din_q    <= din;
            r_pending  <= (r_pending & ~w_load_vec) | w_rise;
            r_overflow <= (r_overflow & ~clr_overflow) | w_ovf_event;
            if (w_load) begin
                r_evt_valid <= 1'b1;
                r_evt_id    <= w_gnt_id;
                r_last      <= w_gnt_id;
            end else if (r_evt_valid && evt_ready) begin
                r_evt_valid <= 1'b0;
            end
        end
    end

    assign evt_valid = r_evt_valid;
    assign evt_id    = r_evt_id;
    assign overflow  = r_overflow;

endmodule

// File: tb/tb_edge_event_arbiter.sv
// Randomised and directed bench for edge_event_arbiter against a per-channel event model.
module tb_edge_event_arbiter;

    localparam int N   = 4;
    localparam int IDW = 2;

    logic           clk;
    logic           resetn;
    logic [N-1:0]   din;
    logic [N-1:0]   mask;
    logic           evt_valid;
    logic           evt_ready;
    logic [IDW-1:0] evt_id;
    logic [N-1:0]   overflow;
    logic [N-1:0]   clr_overflow;

    int n_chk;
    int n_bad;

    // Reference state: one entry per channel.
    bit m_prev [N];
    bit m_pend [N];
    bit m_ovf  [N];
    bit m_vld;
    int m_id;
    int m_last;

    edge_event_arbiter #(.N(N), .IDW(IDW)) dut (
        .clk          (clk),
        .resetn       (resetn),
        .din          (din),
        .mask         (mask),
        .evt_valid    (evt_valid),
        .evt_ready    (evt_ready),
        .evt_id       (evt_id),
        .overflow     (overflow),
        .clr_overflow (clr_overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [N-1:0] m_ovf_vec();
        logic [N-1:0] v;
        v = '0;
        for (int i = 0; i < N; i++) v[i] = m_ovf[i];
        return v;
    endfunction

    // Advance the model by one clock edge using the inputs present at that edge.
    task automatic model_edge();
        int  g;
        bit  load;
        bit  rise;
        bit  taken;
        if (!resetn) begin
            for (int i = 0; i < N; i++) begin
                m_prev[i] = 0; m_pend[i] = 0; m_ovf[i] = 0;
            end
            m_vld  = 0;
            m_id   = 0;
            m_last = N - 1;
            return;
        end
        g = -1;
        for (int s = 1; s <= N; s++) begin
            if (g < 0 && m_pend[(m_last + s) % N]) g = (m_last + s) % N;
        end
        load = (!m_vld || evt_ready) && (g >= 0);
        for (int i = 0; i < N; i++) begin
            rise  = din[i] && !m_prev[i] && mask[i];
            taken = load && (g == i);
            if (rise && m_pend[i] && !taken) m_ovf[i] = 1;
            else if (clr_overflow[i])        m_ovf[i] = 0;
            if (rise)       m_pend[i] = 1;
            else if (taken) m_pend[i] = 0;
            m_prev[i] = din[i];
        end
        if (load) begin
            m_vld  = 1;
            m_id   = g;
            m_last = g;
        end else if (m_vld && evt_ready) begin
            m_vld = 0;
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        chk("valid", 32'(evt_valid), 32'(m_vld));
        chk("id", 32'(evt_id), 32'(m_id));
        chk("overflow", 32'(overflow), 32'(m_ovf_vec()));
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        step();
        resetn = 1'b1;
    endtask

    initial begin
        n_chk = 0;
        n_bad = 0;
        resetn = 1'b0; din = '0; mask = 4'hF; evt_ready = 1'b1; clr_overflow = '0;
        #1;
        step();
        step();
        chk("rst_valid", 32'(evt_valid), 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);
        resetn = 1'b1;
        step();

        // Single event: one cycle from sampling to valid, valid for one cycle.
        din = 4'h1;
        step(); chk("single_pre", 32'(evt_valid), 32'd0);
        step(); chk("single_vld", 32'(evt_valid), 32'd1); chk("single_id", 32'(evt_id), 32'd0);
        step(); chk("single_drop", 32'(evt_valid), 32'd0);
        chk("single_ovf", 32'(overflow), 32'd0);
        din = 4'h0; step();

        // Simultaneous edges from a fresh reset: 0,1,2,3.
        do_reset();
        din = 4'hF; step();
        for (int k = 0; k < N; k++) begin
            step();
            chk("simul_vld", 32'(evt_valid), 32'd1);
            chk("simul_id", 32'(evt_id), 32'(k));
        end
        step(); chk("simul_drop", 32'(evt_valid), 32'd0);

        // Same with last=1: 2,3,0,1.
        din = 4'h0; step();
        din = 4'h2; step(); step(); chk("last1_id", 32'(evt_id), 32'd1);
        din = 4'h0; step(); step();
        din = 4'hF; step();
        for (int k = 0; k < N; k++) begin
            step();
            chk("rot_id", 32'(evt_id), 32'((k + 2) % N));
        end
        din = 4'h0; step(); step();

        // Backpressure and overflow on channel 2.
        evt_ready = 1'b0;
        for (int r = 0; r < 3; r++) begin
            din = 4'h4; step();
            din = 4'h0; step();
        end
        chk("bp_vld", 32'(evt_valid), 32'd1);
        chk("bp_id", 32'(evt_id), 32'd2);
        chk("bp_ovf", 32'(overflow), 32'h4);
        clr_overflow = 4'h4; step(); clr_overflow = 4'h0;
        chk("clr_ovf", 32'(overflow), 32'h0);
        din = 4'h4; clr_overflow = 4'h4; step(); clr_overflow = 4'h0;
        chk("set_wins", 32'(overflow), 32'h4);
        din = 4'h0; clr_overflow = 4'h4; step(); clr_overflow = 4'h0;
        evt_ready = 1'b1;
        for (int k = 0; k < 4; k++) step();
        chk("bp_drain", 32'(evt_valid), 32'd0);

        // Mask: masked rise and unmask-while-high both stay silent.
        mask = 4'hD; din = 4'h2; step(); step();
        chk("mask_off", 32'(evt_valid), 32'd0);
        mask = 4'hF; step(); step();
        chk("mask_high", 32'(evt_valid), 32'd0);
        din = 4'h0; step();
        din = 4'h2; step(); step();
        chk("mask_on_vld", 32'(evt_valid), 32'd1);
        chk("mask_on_id", 32'(evt_id), 32'd1);
        din = 4'h0; step(); step();

        // Reset with pending events and a stalled output.
        evt_ready = 1'b0;
        din = 4'hA; step(); step();
        din = 4'h0; step();
        din = 4'hA; step();
        chk("pre_rst_vld", 32'(evt_valid), 32'd1);
        din = 4'h1;
        do_reset();
        chk("mid_rst_vld", 32'(evt_valid), 32'd0);
        chk("mid_rst_ovf", 32'(overflow), 32'd0);
        step(); step();
        chk("post_rst_vld", 32'(evt_valid), 32'd1);
        chk("post_rst_id", 32'(evt_id), 32'd0);
        evt_ready = 1'b1; step();
        chk("post_rst_empty", 32'(evt_valid), 32'd0);
        din = 4'h0; step();

        // Load and rise of channel 3 in the same cycle.
        evt_ready = 1'b0;
        din = 4'h1; step(); step();
        din = 4'h9; step();
        din = 4'h1; step();
        evt_ready = 1'b1; din = 4'h9; step();
        chk("lr_first", 32'(evt_id), 32'd3);
        chk("lr_ovf", 32'(overflow), 32'd0);
        step();
        chk("lr_second_vld", 32'(evt_valid), 32'd1);
        chk("lr_second_id", 32'(evt_id), 32'd3);
        step();
        chk("lr_drop", 32'(evt_valid), 32'd0);
        din = 4'h0; step();

        // Random traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            din          = 4'($urandom);
            mask         = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
            evt_ready    = ($urandom_range(0, 2) != 0);
            clr_overflow = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'h0;
            resetn       = ($urandom_range(0, 199) != 0);
            step();
        end

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
